// File: rtl/audio_fx_pkg.sv
// Shared types and helpers for the audio gain/mute stage.
package audio_fx_pkg;

    typedef enum logic [1:0] {
        UNMUTED   = 2'd0,
        RAMP_DOWN = 2'd1,
        MUTED     = 2'd2,
        RAMP_UP   = 2'd3
    } ramp_state_t;

    localparam int GAIN_FRAC_W = 6;
    localparam int UNITY_GAIN  = 1 << GAIN_FRAC_W;

    // Clamp a sign-extended value into the signed range of a w-bit sample.
    function automatic logic signed [63:0] saturate(input logic signed [63:0] y, input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (y > hi) return hi;
        if (y < lo) return lo;
        return y;
    endfunction

endpackage

// File: rtl/audio_stream_gain_mute_if.sv
// Per-lane valid/ready stream bundle between sources, this stage and sinks.
interface audio_stream_gain_mute_if #(
    parameter int DATA_W = 16,
    parameter int NUM_CH = 2
);
    logic [NUM_CH-1:0][DATA_W-1:0] in_data;
    logic [NUM_CH-1:0]             in_valid;
    logic [NUM_CH-1:0]             in_ready;
    logic [NUM_CH-1:0][DATA_W-1:0] out_data;
    logic [NUM_CH-1:0]             out_valid;
    logic [NUM_CH-1:0]             out_ready;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid
    );
endinterface

// File: rtl/audio_stream_gain_mute_lane.sv
// One audio lane: product stage, shift/saturate stage, sticky clip flag.
module audio_fx_lane
    import audio_fx_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int GAIN_W = 8,
    parameter int RAMP_W = 6
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    output logic [DATA_W-1:0] out_data_o,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    input  logic [GAIN_W-1:0] gain_i,
    input  logic [RAMP_W:0]   level_i,
    input  logic              clip_clr_i,
    output logic              clip_o
);
    localparam int PW    = DATA_W + GAIN_W + RAMP_W + 2;
    localparam int SHIFT = GAIN_W - 2 + RAMP_W;

    logic                 s1_valid_q, s1_valid_d;
    logic signed [PW-1:0] s1_p_q, s1_p_d;
    logic                 s2_valid_q, s2_valid_d;
    logic [DATA_W-1:0]    s2_data_q, s2_data_d;
    logic                 clip_q, clip_d;

    logic                 adv2;
    logic                 accept;
    logic signed [PW-1:0] prod;
    logic signed [63:0]   y_full;
    logic signed [63:0]   y_sat;
    logic                 sat_hit;

    assign adv2       = s1_valid_q & (~s2_valid_q | out_ready_i);
    assign in_ready_o = ~s1_valid_q | adv2;
    assign accept     = in_valid_i & in_ready_o;

    assign prod = PW'($signed(in_data_i)) * PW'($signed({1'b0, gain_i}))
                * PW'($signed({1'b0, level_i}));

    // Arithmetic shift floors toward minus infinity, as intended for negatives.
    assign y_full  = 64'(s1_p_q >>> SHIFT);
    assign y_sat   = saturate(y_full, DATA_W);
    assign sat_hit = (y_sat != y_full);

    always_comb begin
        s1_valid_d = accept | (s1_valid_q & ~adv2);
        s1_p_d     = accept ? prod : s1_p_q;
        s2_valid_d = adv2 | (s2_valid_q & ~out_ready_i);
        s2_data_d  = adv2 ? y_sat[DATA_W-1:0] : s2_data_q;
        clip_d     = clip_clr_i ? 1'b0 : (clip_q | (adv2 & sat_hit));
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            s1_valid_q <= 1'b0;
            s1_p_q     <= '0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            clip_q     <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_p_q     <= s1_p_d;
            s2_valid_q <= s2_valid_d;
            s2_data_q  <= s2_data_d;
            clip_q     <= clip_d;
        end
    end

    assign out_data_o  = s2_data_q;
    assign out_valid_o = s2_valid_q;
    assign clip_o      = clip_q;

endmodule

// File: rtl/audio_stream_gain_mute.sv
// N-lane gain/saturate stage with a shared soft-mute ramp driven by lane-0 traffic.
//   state     | meaning
//   UNMUTED   | level held at full scale
//   RAMP_DOWN | level steps down one per lane-0 accept
//   MUTED     | level held at zero
//   RAMP_UP   | level steps up one per lane-0 accept
module audio_stream_gain_mute
    import audio_fx_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int NUM_CH = 2,
    parameter int GAIN_W = 8,
    parameter int RAMP_W = 6
) (
    input  logic                     CLOCK_50,
    input  logic                     RESET_N,
    audio_stream_gain_mute_if.slave  st,
    input  logic [GAIN_W-1:0]        gain,
    input  logic                     mute,
    input  logic                     clip_clr,
    output logic [NUM_CH-1:0]        clip,
    output logic                     muted
);
    localparam logic [RAMP_W:0] LEVEL_MAX = (RAMP_W + 1)'(1 << RAMP_W);

    ramp_state_t       state_q, state_d;
    logic [RAMP_W:0]   level_q, level_d;
    logic [RAMP_W:0]   level_tgt;
    logic              acc0;

    logic [NUM_CH-1:0]             lane_in_ready;
    logic [NUM_CH-1:0]             lane_out_valid;
    logic [NUM_CH-1:0][DATA_W-1:0] lane_out_data;

    assign acc0      = st.in_valid[0] & lane_in_ready[0];
    assign level_tgt = mute ? '0 : LEVEL_MAX;

    // Ramp direction follows mute directly, so a reversal continues from the current level.
    always_comb begin
        state_d = state_q;
        level_d = level_q;
        case (state_q)
            UNMUTED: if (mute)  state_d = RAMP_DOWN;
            MUTED:   if (!mute) state_d = RAMP_UP;
            RAMP_DOWN, RAMP_UP: begin
                if (acc0) begin
                    if (mute && (level_q != '0))             level_d = level_q - 1'b1;
                    else if (!mute && (level_q != LEVEL_MAX)) level_d = level_q + 1'b1;
                end
                if (level_d == level_tgt) state_d = mute ? MUTED : UNMUTED;
                else                      state_d = mute ? RAMP_DOWN : RAMP_UP;
            end
            default: state_d = UNMUTED;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= UNMUTED;
            level_q <= LEVEL_MAX;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
        end
    end

    assign muted = (state_q == MUTED);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
        audio_fx_lane #(
            .DATA_W (DATA_W),
            .GAIN_W (GAIN_W),
            .RAMP_W (RAMP_W)
        ) u_lane (
            .clk_i       (CLOCK_50),
            .rst_n_i     (RESET_N),
            .in_data_i   (st.in_data[i]),
            .in_valid_i  (st.in_valid[i]),
            .in_ready_o  (lane_in_ready[i]),
            .out_data_o  (lane_out_data[i]),
            .out_valid_o (lane_out_valid[i]),
            .out_ready_i (st.out_ready[i]),
            .gain_i      (gain),
            .level_i     (level_q),
            .clip_clr_i  (clip_clr),
            .clip_o      (clip[i])
        );
    end

    assign st.in_ready  = lane_in_ready;
    assign st.out_valid = lane_out_valid;
    assign st.out_data  = lane_out_data;

endmodule

// File: tb/tb_audio_stream_gain_mute.sv
// Scoreboard bench for audio_stream_gain_mute: random and directed traffic vs. a level/gain model.
module tb_audio_stream_gain_mute;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] gain;
    logic       mute;
    logic       clip_clr;
    logic [1:0] clip;
    logic       muted;

    always #5 clk = ~clk;

    audio_stream_gain_mute_if #(.DATA_W(16), .NUM_CH(2)) st ();

    audio_stream_gain_mute #(
        .DATA_W (16),
        .NUM_CH (2),
        .GAIN_W (8),
        .RAMP_W (6)
    ) dut (
        .CLOCK_50 (clk),
        .RESET_N  (rst_n),
        .st       (st.slave),
        .gain     (gain),
        .mute     (mute),
        .clip_clr (clip_clr),
        .clip     (clip),
        .muted    (muted)
    );

    int tests = 0;
    int fails = 0;

    logic [15:0] q0[$];
    logic [15:0] q1[$];
    logic [15:0] log0[$];
    int          acc_cnt[2];
    int          mdl_lvl = 64;
    bit          mdl_ramp = 1'b0;
    bit          acct_en = 1'b0;
    bit          occ_en = 1'b0;
    bit          prev_stall[2];
    logic [15:0] prev_data[2];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
        tests++;
        if (act !== exp_v) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp_v, $time);
        end
    endtask

    // Sample times gain times level over 64*64, floored, then clamped to 16-bit signed.
    function automatic logic [15:0] exp_y(input logic [15:0] x, input logic [7:0] g, input int l);
        longint p;
        p = longint'($signed(x)) * longint'(g) * longint'(l);
        p = p >>> 12;
        if (p > 32767)  p = 32767;
        if (p < -32768) p = -32768;
        return p[15:0];
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Stimulus accounting: expected outputs pushed at acceptance; level model advanced.
    always @(negedge clk) begin
        if (rst_n && acct_en) begin
            bit a0;
            int tgt;
            check("muted", muted, (!mdl_ramp && mdl_lvl == 0));
            for (int i = 0; i < 2; i++) begin
                if (st.in_valid[i] && st.in_ready[i]) begin
                    if (i == 0) q0.push_back(exp_y(st.in_data[i], gain, mdl_lvl));
                    else        q1.push_back(exp_y(st.in_data[i], gain, mdl_lvl));
                    acc_cnt[i]++;
                end
            end
            a0 = st.in_valid[0] && st.in_ready[0];
            if (mdl_ramp && a0) begin
                mdl_lvl = mdl_lvl + (mute ? -1 : 1);
                if (mdl_lvl < 0)  mdl_lvl = 0;
                if (mdl_lvl > 64) mdl_lvl = 64;
            end
            tgt = mute ? 0 : 64;
            mdl_ramp = (mdl_lvl != tgt);
        end
    end

    // Output monitor: pop and compare on every emit, plus hold-stability under stall.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall[0] = 1'b0;
            prev_stall[1] = 1'b0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (prev_stall[i]) begin
                    check("hold_valid", st.out_valid[i], 1'b1);
                    check("hold_data", st.out_data[i], prev_data[i]);
                end
                if (st.out_valid[i] && st.out_ready[i]) begin
                    logic [15:0] e;
                    if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
                        check(i == 0 ? "sb_extra0" : "sb_extra1", st.out_data[i], 64'hFFFF_FFFF);
                    end else begin
                        e = (i == 0) ? q0.pop_front() : q1.pop_front();
                        check(i == 0 ? "sb_lane0" : "sb_lane1", st.out_data[i], e);
                    end
                    if (i == 0) log0.push_back(st.out_data[0]);
                end
                prev_stall[i] = st.out_valid[i] && !st.out_ready[i];
                prev_data[i]  = st.out_data[i];
            end
        end
    end

    always @(posedge clk) begin
        if (occ_en) begin
            check("occ_lane0", (q0.size() <= 2), 1'b1);
            check("occ_lane1", (q1.size() <= 2), 1'b1);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int rdy_cnt;
        int ov_cnt;
        int cyc_n;
        int j;
        int n;

        rst_n       = 1'b0;
        gain        = 8'd64;
        mute        = 1'b0;
        clip_clr    = 1'b0;
        st.in_valid = '0;
        st.in_data  = '0;
        st.out_ready = '0;
        acc_cnt[0] = 0;
        acc_cnt[1] = 0;

        #3;
        check("rst_out_valid", st.out_valid, 2'b00);
        check("rst_out_data", st.out_data, 32'h0);
        check("rst_clip", clip, 2'b00);
        check("rst_muted", muted, 1'b0);
        #20 rst_n = 1'b1;
        acct_en = 1'b1;
        cyc();
        check("rst_in_ready", st.in_ready, 2'b11);

        // Unity pass and latency
        st.out_ready = 2'b11;
        st.in_valid  = 2'b01;
        st.in_data[0] = 16'h1234;
        cyc();
        st.in_valid = 2'b00;
        @(negedge clk);
        check("lat_edge1_valid", st.out_valid[0], 1'b0);
        cyc();
        check("lat_edge2_valid", st.out_valid[0], 1'b1);
        check("unity_data", st.out_data[0], 16'h1234);

        // Continuous stream on both lanes
        rdy_cnt = 0;
        ov_cnt  = 0;
        for (int k = 0; k < 40; k++) begin
            cyc();
            st.in_valid   = 2'b11;
            st.in_data[0] = 16'($urandom);
            st.in_data[1] = 16'($urandom);
            @(negedge clk);
            if (st.in_ready == 2'b11) rdy_cnt++;
            if (k >= 2 && st.out_valid == 2'b11) ov_cnt++;
        end
        cyc();
        st.in_valid = 2'b00;
        check("stream_ready_cycles", rdy_cnt, 40);
        check("stream_valid_cycles", ov_cnt, 38);
        repeat (4) cyc();

        // Saturation and clip flag
        gain = 8'd128;
        st.in_valid   = 2'b01;
        st.in_data[0] = 16'h5000;
        cyc();
        st.in_data[0] = 16'h8000;
        cyc();
        st.in_valid = 2'b00;
        repeat (3) cyc();
        check("clip_set", clip, 2'b01);
        clip_clr = 1'b1;
        cyc();
        clip_clr = 1'b0;
        check("clip_cleared", clip, 2'b00);
        clip_clr = 1'b1;
        st.in_valid   = 2'b01;
        st.in_data[0] = 16'h5000;
        cyc();
        st.in_valid = 2'b00;
        repeat (3) cyc();
        clip_clr = 1'b0;
        check("clip_clr_priority", clip, 2'b00);
        cyc();

        // Random traffic with 25% sink readiness
        acc_cnt[0] = 0;
        acc_cnt[1] = 0;
        cyc_n  = 0;
        occ_en = 1'b1;
        while ((acc_cnt[0] < 1000 || acc_cnt[1] < 1000) && cyc_n < 30000) begin
            cyc();
            cyc_n++;
            for (int i = 0; i < 2; i++) begin
                st.in_valid[i]  = 1'($urandom_range(0, 1));
                st.in_data[i]   = 16'($urandom);
                st.out_ready[i] = ($urandom_range(0, 3) == 0);
            end
            gain = 8'($urandom_range(0, 255));
        end
        check("rand_budget", (cyc_n < 30000), 1'b1);
        st.in_valid  = 2'b00;
        st.out_ready = 2'b11;
        repeat (6) cyc();
        occ_en = 1'b0;
        check("rand_drain0", q0.size(), 0);
        check("rand_drain1", q1.size(), 0);

        // Mute ramp on constant 0x4000
        gain = 8'd64;
        clip_clr = 1'b1;
        cyc();
        clip_clr = 1'b0;
        st.in_valid   = 2'b01;
        st.in_data[0] = 16'h4000;
        repeat (3) cyc();
        log0.delete();
        mute = 1'b1;
        repeat (72) cyc();
        check("mute_muted", muted, 1'b1);
        j = 0;
        while (j < log0.size() && log0[j] == 16'h4000) j++;
        check("ramp_len", (log0.size() >= j + 64), 1'b1);
        for (int k = 0; k < 64; k++) begin
            if (j + k < log0.size())
                check("ramp_step", log0[j + k], 64'((63 - k) * 256));
        end

        // Ramp back up, then reverse mid-ramp at level 32
        mute = 1'b0;
        repeat (70) cyc();
        check("unmute_muted", muted, 1'b0);
        check("unmute_data", st.out_data[0], 16'h4000);
        log0.delete();
        mute = 1'b1;
        n = 0;
        while (mdl_lvl != 32 && n < 200) begin
            cyc();
            n++;
        end
        check("reach_level32", (n < 200), 1'b1);
        mute = 1'b0;
        repeat (40) cyc();
        j = 0;
        while (j < log0.size() && log0[j] != 16'h2000) j++;
        check("rev_found", (j + 2 < log0.size()), 1'b1);
        if (j + 2 < log0.size()) begin
            check("rev_next1", log0[j + 1], 16'h2100);
            check("rev_next2", log0[j + 2], 16'h2200);
        end
        check("rev_final", st.out_data[0], 16'h4000);
        check("rev_muted", muted, 1'b0);

        // Async reset mid-stream with sink stalled
        gain = 8'd128;
        st.out_ready  = 2'b00;
        st.in_valid   = 2'b11;
        st.in_data[0] = 16'h1000;
        st.in_data[1] = 16'h5000;
        repeat (4) cyc();
        check("pre_rst_valid", st.out_valid, 2'b11);
        check("pre_rst_clip", clip, 2'b10);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_valid", st.out_valid, 2'b00);
        check("async_rst_clip", clip, 2'b00);
        check("async_rst_data", st.out_data, 32'h0);
        q0.delete();
        q1.delete();
        mdl_lvl  = 64;
        mdl_ramp = 1'b0;
        st.in_valid  = 2'b00;
        gain         = 8'd64;
        st.out_ready = 2'b11;
        #2 rst_n = 1'b1;
        cyc();
        check("post_rst_ready", st.in_ready, 2'b11);
        st.in_valid   = 2'b01;
        st.in_data[0] = 16'h0ABC;
        cyc();
        st.in_valid = 2'b00;
        cyc();
        check("post_rst_valid", st.out_valid[0], 1'b1);
        check("post_rst_data", st.out_data[0], 16'h0ABC);
        repeat (3) cyc();
        check("final_drain0", q0.size(), 0);
        check("final_drain1", q1.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
